// File: rtl/port_arbiter.sv
// port_arbiter: output-port arbiter for a 16-input serial packet switch.
// Every input runs a small FSM that decodes the LSB-first destination address.
// Inputs whose packets target this port compete round-robin for the one-hot
// select that drives the output-port data mux. Once granted, an owner keeps
// the select until its frame ends.
module port_arbiter #(
  parameter int unsigned PORT_ID   = 0,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] frame_n,
  input  logic [15:0] valid_n,
  input  logic [15:0] din,
  output logic [15:0] grant,
  output logic        busy_o,
  output logic [15:0] wait_o
);

  localparam int unsigned          NUM_IN       = 16;
  localparam int unsigned          CNT_W        = (ADDR_BITS > 2) ? $clog2(ADDR_BITS) : 1;
  localparam logic [CNT_W-1:0]     LAST_CNT     = CNT_W'(ADDR_BITS - 1);
  localparam logic [ADDR_BITS-1:0] PORT_ADDR    = ADDR_BITS'(PORT_ID);
  localparam logic                 ONE_BIT_ADDR = (ADDR_BITS == 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_REQ  = 3'd2,
    ST_OWN  = 3'd3,
    ST_SKIP = 3'd4
  } arb_state_e;

  // Per-input state.
  arb_state_e [NUM_IN-1:0]                state_r;
  logic       [NUM_IN-1:0][ADDR_BITS-1:0] addr_r;
  logic       [NUM_IN-1:0][CNT_W-1:0]     cnt_r;
  // An input may only start a packet after its frame_n has been seen high.
  // This discards the tail of a frame that was still low when reset released.
  logic       [NUM_IN-1:0]                armed_r;

  // Arbiter state and registered outputs.
  logic [NUM_IN-1:0] grant_r;
  logic [NUM_IN-1:0] wait_r;
  logic              busy_r;
  logic [3:0]        last_owner_r;

  // Combinational helpers.
  logic [NUM_IN-1:0][ADDR_BITS-1:0] addr_shift_s;
  logic [NUM_IN-1:0]                last_bit_s;
  logic [NUM_IN-1:0]                match_s;
  logic [NUM_IN-1:0]                req_s;
  logic [NUM_IN-1:0]                grant_next_s;
  logic [3:0]                       owner_next_s;
  logic [4:0]                       pick_s;
  logic                             valid_unused_s;

  // Shift one serial address bit in at the MSB, so the first bit received
  // ends up at the LSB after ADDR_BITS shifts.
  function automatic logic [ADDR_BITS-1:0] shift_in(input logic [ADDR_BITS-1:0] addr,
                                                    input logic                 bit_in);
    logic [ADDR_BITS-1:0] res;
    res = addr >> 1;
    res[ADDR_BITS-1] = bit_in;
    return res;
  endfunction

  // Round-robin search starting at (last + 1) mod 16. Bit 4 of the result is
  // the "found" flag and bits 3:0 are the winning index. The loop scans from
  // lowest to highest priority so that the highest-priority hit is written last.
  function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] last);
    logic [4:0] res;
    logic [3:0] idx;
    res = 5'd0;
    idx = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      idx = last + 4'd1 + 4'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Per-input address decode: next shift value, last-bit detect, match and request.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      addr_shift_s[i] = shift_in((state_r[i] == ST_IDLE) ? '0 : addr_r[i], din[i]);
      last_bit_s[i]   = (state_r[i] == ST_IDLE) ? ONE_BIT_ADDR : (cnt_r[i] == LAST_CNT);
      match_s[i]      = (addr_shift_s[i] == PORT_ADDR);
      req_s[i]        = (state_r[i] == ST_REQ);
    end
  end

  // Next grant: the owner holds it until it samples frame_n high. When no
  // grant is active, a round-robin winner is chosen. The edge that clears a
  // grant never issues a new one, which leaves one idle cycle between owners.
  always_comb begin
    grant_next_s = '0;
    owner_next_s = last_owner_r;
    pick_s       = 5'd0;
    if (grant_r != 16'h0000) begin
      grant_next_s = grant_r & ~frame_n;
    end else begin
      pick_s = rr_pick(req_s, last_owner_r);
      if (pick_s[4]) begin
        grant_next_s[pick_s[3:0]] = 1'b1;
        owner_next_s              = pick_s[3:0];
      end else begin
        owner_next_s = last_owner_r;
      end
    end
  end

  // Per-input packet FSMs, serial address capture and registered wait flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_IN; i++) begin
        state_r[i] <= ST_IDLE;
      end
      addr_r  <= '0;
      cnt_r   <= '0;
      armed_r <= '0;
      wait_r  <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        armed_r[i] <= armed_r[i] | frame_n[i];
        wait_r[i]  <= 1'b0;
        case (state_r[i])
          ST_IDLE: begin
            if (!frame_n[i] && armed_r[i]) begin
              addr_r[i] <= addr_shift_s[i];
              if (last_bit_s[i]) begin
                cnt_r[i]   <= '0;
                state_r[i] <= match_s[i] ? ST_REQ : ST_SKIP;
                wait_r[i]  <= match_s[i];
              end else begin
                cnt_r[i]   <= CNT_W'(1);
                state_r[i] <= ST_ADDR;
              end
            end else begin
              addr_r[i]  <= '0;
              cnt_r[i]   <= '0;
              state_r[i] <= ST_IDLE;
            end
          end
          ST_ADDR: begin
            if (frame_n[i]) begin
              // The frame ended before the full address arrived: drop it.
              addr_r[i]  <= '0;
              cnt_r[i]   <= '0;
              state_r[i] <= ST_IDLE;
            end else begin
              addr_r[i] <= addr_shift_s[i];
              if (last_bit_s[i]) begin
                cnt_r[i]   <= '0;
                state_r[i] <= match_s[i] ? ST_REQ : ST_SKIP;
                wait_r[i]  <= match_s[i];
              end else begin
                cnt_r[i]   <= cnt_r[i] + CNT_W'(1);
                state_r[i] <= ST_ADDR;
              end
            end
          end
          ST_REQ: begin
            // Sender holds its request until granted, whatever frame_n does.
            if (grant_next_s[i]) begin
              state_r[i] <= ST_OWN;
              wait_r[i]  <= 1'b0;
            end else begin
              state_r[i] <= ST_REQ;
              wait_r[i]  <= 1'b1;
            end
          end
          ST_OWN: begin
            if (frame_n[i]) begin
              state_r[i] <= ST_IDLE;
            end else begin
              state_r[i] <= ST_OWN;
            end
          end
          ST_SKIP: begin
            if (frame_n[i]) begin
              state_r[i] <= ST_IDLE;
            end else begin
              state_r[i] <= ST_SKIP;
            end
          end
          default: begin
            state_r[i] <= ST_IDLE;
            addr_r[i]  <= '0;
            cnt_r[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Output-port select, busy flag and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_r      <= '0;
      busy_r       <= 1'b0;
      last_owner_r <= 4'd15;
    end else begin
      grant_r      <= grant_next_s;
      busy_r       <= |grant_next_s;
      last_owner_r <= owner_next_s;
    end
  end

  assign grant  = grant_r;
  assign busy_o = busy_r;
  assign wait_o = wait_r;

  // valid_n only travels with the data to the downstream mux. It plays no
  // part in arbitration, so it is folded into an unused net here.
  assign valid_unused_s = ^valid_n;

endmodule
